// File: rtl/ctrl_step_sequencer_pkg.sv
// mini_src_ctrl_pkg
// Shared definitions for the Mini SRC control-step sequencer:
//   - state_e     : FSM states with fixed 4-bit encodings (visible on state_o)
//   - ALU_*       : alu_control operation codes
//   - OP_*        : instruction opcodes handled by the register-register execute
//   - alu_map()   : opcode -> ALU operation, ALU_NOP for unmapped opcodes
//   - is_legal()  : opcode has an execute sequence in this sequencer
package mini_src_ctrl_pkg;

  localparam int OPC_FIELD_W = 5;
  localparam int ALU_FIELD_W = 5;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6
  } state_e;

  localparam logic [ALU_FIELD_W-1:0] ALU_NOP  = 5'b00000;
  localparam logic [ALU_FIELD_W-1:0] ALU_ADD  = 5'b00001;
  localparam logic [ALU_FIELD_W-1:0] ALU_SUB  = 5'b00010;
  localparam logic [ALU_FIELD_W-1:0] ALU_AND  = 5'b00011;
  localparam logic [ALU_FIELD_W-1:0] ALU_OR   = 5'b00100;
  localparam logic [ALU_FIELD_W-1:0] ALU_SHR  = 5'b00101;
  localparam logic [ALU_FIELD_W-1:0] ALU_SHRA = 5'b00110;
  localparam logic [ALU_FIELD_W-1:0] ALU_SHL  = 5'b00111;
  localparam logic [ALU_FIELD_W-1:0] ALU_ROR  = 5'b01000;
  localparam logic [ALU_FIELD_W-1:0] ALU_ROL  = 5'b01001;
  localparam logic [ALU_FIELD_W-1:0] ALU_INC  = 5'b11111;

  localparam logic [OPC_FIELD_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_FIELD_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_FIELD_W-1:0] OP_ROR  = 5'b00101;
  localparam logic [OPC_FIELD_W-1:0] OP_ROL  = 5'b00110;
  localparam logic [OPC_FIELD_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPC_FIELD_W-1:0] OP_SHRA = 5'b01000;
  localparam logic [OPC_FIELD_W-1:0] OP_SHL  = 5'b01001;
  localparam logic [OPC_FIELD_W-1:0] OP_AND  = 5'b01010;
  localparam logic [OPC_FIELD_W-1:0] OP_OR   = 5'b01011;

  // Unmapped opcodes return ALU_NOP; callers gate on is_legal() anyway.
  function automatic logic [ALU_FIELD_W-1:0] alu_map(input logic [OPC_FIELD_W-1:0] opc);
    logic [ALU_FIELD_W-1:0] op;
    case (opc)
      OP_ADD:  op = ALU_ADD;
      OP_SUB:  op = ALU_SUB;
      OP_ROR:  op = ALU_ROR;
      OP_ROL:  op = ALU_ROL;
      OP_SHR:  op = ALU_SHR;
      OP_SHRA: op = ALU_SHRA;
      OP_SHL:  op = ALU_SHL;
      OP_AND:  op = ALU_AND;
      OP_OR:   op = ALU_OR;
      default: op = ALU_NOP;
    endcase
    return op;
  endfunction

  function automatic logic is_legal(input logic [OPC_FIELD_W-1:0] opc);
    return alu_map(opc) != ALU_NOP;
  endfunction

endpackage

// File: rtl/ctrl_step_sequencer_if.sv
// ctrl_step_sequencer_if
// Bundle between the control-step sequencer and the Mini SRC datapath/test side.
//   inputs to sequencer : run, mem_ready, ir
//   outputs             : r_out/r_in one-hot selects, datapath strobes,
//                         alu_control, state_o, instr_done, illegal
// modport slave is the sequencer; modport master is whoever drives it.
interface ctrl_step_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int ALU_W  = 5
);

  logic              run;
  logic              mem_ready;
  logic [DATA_W-1:0] ir;

  logic [NREGS-1:0]  r_out;
  logic [NREGS-1:0]  r_in;
  logic              p_out;
  logic              p_en;
  logic              mar_en;
  logic              mdr_en;
  logic              mdr_out;
  logic              read;
  logic              ir_en;
  logic              y_en;
  logic              zlo_en;
  logic              zlo_out;
  logic [ALU_W-1:0]  alu_control;
  logic [3:0]        state_o;
  logic              instr_done;
  logic              illegal;

  modport master (
    output run, mem_ready, ir,
    input  r_out, r_in, p_out, p_en, mar_en, mdr_en, mdr_out, read, ir_en,
           y_en, zlo_en, zlo_out, alu_control, state_o, instr_done, illegal
  );

  modport slave (
    input  run, mem_ready, ir,
    output r_out, r_in, p_out, p_en, mar_en, mdr_en, mdr_out, read, ir_en,
           y_en, zlo_en, zlo_out, alu_control, state_o, instr_done, illegal
  );

endinterface

// File: rtl/ctrl_step_sequencer_ir_decode.sv
// ctrl_ir_decode
// Purely combinational IR field extraction for register-register ALU ops.
//   ir     : instruction register contents
//   opc    : ir[DATA_W-1 -: OPC_W]
//   ra_oh  : one-hot of ra (destination)
//   rb_oh  : one-hot of rb (first source)
//   rc_oh  : one-hot of rc (second source)
module ctrl_ir_decode #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int OPC_W  = 5
) (
  input  logic [DATA_W-1:0] ir,
  output logic [OPC_W-1:0]  opc,
  output logic [NREGS-1:0]  ra_oh,
  output logic [NREGS-1:0]  rb_oh,
  output logic [NREGS-1:0]  rc_oh
);

  localparam int REG_AW   = $clog2(NREGS);
  localparam int RA_MSB   = DATA_W - 1 - OPC_W;
  localparam int RB_MSB   = RA_MSB - REG_AW;
  localparam int RC_MSB   = RB_MSB - REG_AW;
  localparam int TAIL_MSB = RC_MSB - REG_AW;

  localparam logic [NREGS-1:0] ONE = NREGS'(1);

  logic [REG_AW-1:0] ra;
  logic [REG_AW-1:0] rb;
  logic [REG_AW-1:0] rc;

  // Low IR bits (immediates etc.) carry no meaning for this instruction class.
  logic unused_ir_tail;

  assign opc = ir[DATA_W-1 -: OPC_W];
  assign ra  = ir[RA_MSB -: REG_AW];
  assign rb  = ir[RB_MSB -: REG_AW];
  assign rc  = ir[RC_MSB -: REG_AW];

  assign unused_ir_tail = ^ir[TAIL_MSB:0];

  // A shift decoder yields all zeros if a field exceeds NREGS-1, which keeps
  // the select at most one-hot when NREGS is not a power of two.
  assign ra_oh = ONE << ra;
  assign rb_oh = ONE << rb;
  assign rc_oh = ONE << rc;

endmodule

// File: rtl/ctrl_step_sequencer.sv
// ctrl_step_sequencer
// Mini SRC control-step FSM: instruction fetch (T0-T2) with a memory ready
// handshake, then register-register ALU execute (T3-T5).
//   clk  : rising-edge clock
//   clr  : synchronous active-high reset, overrides run and mem_ready
//   bus  : slave side of ctrl_step_sequencer_if (run, mem_ready, ir in;
//          one-hot r_out/r_in, datapath strobes, alu_control, state_o,
//          instr_done and illegal out)
// Outputs are a Moore decode of the registered state and the current IR.
module ctrl_step_sequencer
  import mini_src_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int OPC_W  = 5,
  parameter int ALU_W  = 5
) (
  input logic                 clk,
  input logic                 clr,
  ctrl_step_sequencer_if.slave bus
);

  localparam int REG_AW = $clog2(NREGS);

  state_e state_q;
  state_e state_d;

  logic [OPC_W-1:0] opc;
  logic [NREGS-1:0] ra_oh;
  logic [NREGS-1:0] rb_oh;
  logic [NREGS-1:0] rc_oh;
  logic             opc_legal;
  logic [ALU_W-1:0] alu_exec;

  logic [NREGS-1:0] r_out;
  logic [NREGS-1:0] r_in;
  logic             p_out;
  logic             p_en;
  logic             mar_en;
  logic             mdr_en;
  logic             mdr_out;
  logic             read;
  logic             ir_en;
  logic             y_en;
  logic             zlo_en;
  logic             zlo_out;
  logic [ALU_W-1:0] alu_control;
  logic             instr_done;
  logic             illegal;

  ctrl_ir_decode #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .OPC_W  (OPC_W)
  ) u_decode (
    .ir    (bus.ir),
    .opc   (opc),
    .ra_oh (ra_oh),
    .rb_oh (rb_oh),
    .rc_oh (rc_oh)
  );

  assign opc_legal = is_legal(OPC_FIELD_W'(opc));
  assign alu_exec  = ALU_W'(alu_map(OPC_FIELD_W'(opc)));

  always_ff @(posedge clk) begin
    if (clr) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    r_out       = '0;
    r_in        = '0;
    p_out       = 1'b0;
    p_en        = 1'b0;
    mar_en      = 1'b0;
    mdr_en      = 1'b0;
    mdr_out     = 1'b0;
    read        = 1'b0;
    ir_en       = 1'b0;
    y_en        = 1'b0;
    zlo_en      = 1'b0;
    zlo_out     = 1'b0;
    alu_control = '0;
    instr_done  = 1'b0;
    illegal     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_T0;
      end
      // PC -> MAR while the ALU computes PC+1 into ZLO.
      S_T0: begin
        p_out       = 1'b1;
        mar_en      = 1'b1;
        zlo_en      = 1'b1;
        alu_control = ALU_W'(ALU_INC);
        state_d     = S_T1;
      end
      // Strobes are held through the wait; reloading PC from an unchanged ZLO
      // is harmless, and MDR keeps the data from the mem_ready edge.
      S_T1: begin
        zlo_out = 1'b1;
        p_en    = 1'b1;
        read    = 1'b1;
        mdr_en  = 1'b1;
        if (bus.mem_ready) state_d = S_T2;
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_en   = 1'b1;
        state_d = S_T3;
      end
      // Unmapped opcodes abort here without touching any register.
      S_T3: begin
        if (opc_legal) begin
          r_out   = rb_oh;
          y_en    = 1'b1;
          state_d = S_T4;
        end else begin
          illegal = 1'b1;
          state_d = bus.run ? S_T0 : S_IDLE;
        end
      end
      S_T4: begin
        r_out       = rc_oh;
        alu_control = alu_exec;
        zlo_en      = 1'b1;
        state_d     = S_T5;
      end
      S_T5: begin
        zlo_out    = 1'b1;
        r_in       = ra_oh;
        instr_done = 1'b1;
        state_d    = bus.run ? S_T0 : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.r_out       = r_out;
  assign bus.r_in        = r_in;
  assign bus.p_out       = p_out;
  assign bus.p_en        = p_en;
  assign bus.mar_en      = mar_en;
  assign bus.mdr_en      = mdr_en;
  assign bus.mdr_out     = mdr_out;
  assign bus.read        = read;
  assign bus.ir_en       = ir_en;
  assign bus.y_en        = y_en;
  assign bus.zlo_en      = zlo_en;
  assign bus.zlo_out     = zlo_out;
  assign bus.alu_control = alu_control;
  assign bus.state_o     = state_q;
  assign bus.instr_done  = instr_done;
  assign bus.illegal     = illegal;

  // REG_AW documents the IR field width; the decoder derives its own copy.
  logic [31:0] unused_reg_aw;
  assign unused_reg_aw = REG_AW;

endmodule
